// File: rtl/xeng_pkg.sv
// Shared widths, derived sizes and FSM encoding for the X-engine sequencer.
package xeng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2,
    ST_ABORT     = 2'd3
  } seq_state_t;

  function automatic int xlog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Dual-pol complex sample, P parallel samples per word.
  function automatic int calc_input_width(input int bitwidth, input int p_factor_bits);
    return 4 * bitwidth * (1 << p_factor_bits);
  endfunction

  // Four complex pol products, each grown by the multiply and the accumulation depth.
  function automatic int calc_acc_width(input int bitwidth, input int serial_acc_len_bits,
                                        input int p_factor_bits);
    return 8 * (2 * bitwidth + 1 + serial_acc_len_bits + p_factor_bits);
  endfunction

  function automatic int calc_ant_bits(input int n_ants);
    return xlog2(n_ants);
  endfunction

  function automatic int calc_n_taps(input int n_ants);
    return n_ants / 2 + 1;
  endfunction

  function automatic int calc_res_per_win(input int n_ants);
    return n_ants * calc_n_taps(n_ants);
  endfunction

endpackage

// File: rtl/xeng_res_tagger.sv
// Registers tap-chain results, tags them with baseline/window indices and
// checks the per-window result count against a delayed window marker.
module xeng_res_tagger
  import xeng_pkg::*;
#(
  parameter int ACC_WIDTH    = 88,
  parameter int RES_PER_WIN  = 12,
  parameter int BL_BITS      = 4,
  parameter int WIN_CNT_BITS = 16,
  parameter int MARK_DELAY   = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_ce,
  input  logic                    i_tap_rst,
  input  logic                    i_err_clr,
  input  logic                    i_acc_valid,
  input  logic [ACC_WIDTH-1:0]    i_acc,
  output logic [ACC_WIDTH-1:0]    o_acc,
  output logic                    o_acc_valid,
  output logic [BL_BITS-1:0]      o_bl_idx,
  output logic [WIN_CNT_BITS-1:0] o_win_idx,
  output logic                    o_err_cnt
);

  localparam int MARK_BITS = xlog2(MARK_DELAY + 1);
  localparam logic [BL_BITS-1:0] BL_LAST = BL_BITS'(RES_PER_WIN - 1);

  logic [MARK_BITS-1:0]    r_mark_cnt;
  logic                    r_mark_pend;
  logic [BL_BITS-1:0]      r_bl_cnt;
  logic [WIN_CNT_BITS-1:0] r_win_cnt;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic                    r_acc_valid;
  logic [BL_BITS-1:0]      r_bl_idx;
  logic [WIN_CNT_BITS-1:0] r_win_idx;
  logic                    r_err_cnt;
  logic                    w_mark;
  logic                    w_restart;
  logic                    w_bad_count;
  logic                    w_wrap;
  logic [BL_BITS-1:0]      w_bl_cur;
  logic [WIN_CNT_BITS-1:0] w_win_cur;

  // A marker stays pending until the first result after it; a partial window
  // at that point is flagged and closed so the new one starts at baseline 0.
  always_comb begin
    w_mark      = r_mark_pend || (r_mark_cnt == MARK_BITS'(1));
    w_restart   = i_acc_valid && w_mark;
    w_bad_count = w_restart && (r_bl_cnt != '0);
    w_bl_cur    = w_restart ? '0 : r_bl_cnt;
    w_win_cur   = w_bad_count ? r_win_cnt + 1'b1 : r_win_cnt;
    w_wrap      = (w_bl_cur == BL_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mark_cnt  <= '0;
      r_mark_pend <= 1'b0;
      r_bl_cnt    <= '0;
      r_win_cnt   <= '0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      r_bl_idx    <= '0;
      r_win_idx   <= '0;
      r_err_cnt   <= 1'b0;
    end else if (i_ce) begin
      if (i_tap_rst) r_mark_cnt <= MARK_BITS'(MARK_DELAY);
      else if (r_mark_cnt != '0) r_mark_cnt <= r_mark_cnt - 1'b1;
      if (w_restart) r_mark_pend <= 1'b0;
      else if (r_mark_cnt == MARK_BITS'(1)) r_mark_pend <= 1'b1;
      r_acc       <= i_acc;
      r_acc_valid <= i_acc_valid;
      if (i_acc_valid) begin
        r_bl_idx  <= w_bl_cur;
        r_win_idx <= w_win_cur;
        r_bl_cnt  <= w_wrap ? '0 : w_bl_cur + 1'b1;
        r_win_cnt <= w_wrap ? w_win_cur + 1'b1 : w_win_cur;
      end
      if (i_err_clr) r_err_cnt <= 1'b0;
      else if (w_bad_count) r_err_cnt <= 1'b1;
    end
  end

  assign o_acc       = r_acc;
  assign o_acc_valid = r_acc_valid;
  assign o_bl_idx    = r_bl_idx;
  assign o_win_idx   = r_win_idx;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: rtl/xeng_seq_ctrl.sv
// Sequencer for a baseline_tap chain: aligns the antenna-major input stream to
// sync, drives tap 0 with data and accumulator reset, and tags chain results.
module xeng_seq_ctrl
  import xeng_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int P_FACTOR_BITS       = 0,
  parameter int BITWIDTH            = 4,
  parameter int N_ANTS              = 8,
  parameter int WIN_CNT_BITS        = 16,
  localparam int INPUT_WIDTH = calc_input_width(BITWIDTH, P_FACTOR_BITS),
  localparam int ACC_WIDTH   = calc_acc_width(BITWIDTH, SERIAL_ACC_LEN_BITS, P_FACTOR_BITS),
  localparam int RES_PER_WIN = calc_res_per_win(N_ANTS),
  localparam int BL_BITS     = xlog2(RES_PER_WIN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    arm,
  input  logic                    sync_in,
  input  logic                    din_valid,
  input  logic [INPUT_WIDTH-1:0]  din,
  output logic [INPUT_WIDTH-1:0]  tap_a,
  output logic                    tap_rst,
  input  logic [ACC_WIDTH-1:0]    acc_in,
  input  logic                    acc_valid_in,
  output logic [ACC_WIDTH-1:0]    acc_out,
  output logic                    acc_valid_out,
  output logic [BL_BITS-1:0]      bl_idx,
  output logic [WIN_CNT_BITS-1:0] win_idx,
  output logic                    running,
  output logic                    err_gap,
  output logic                    err_cnt
);

  localparam int ANT_BITS   = calc_ant_bits(N_ANTS);
  localparam int MARK_DELAY = calc_n_taps(N_ANTS) * (1 << SERIAL_ACC_LEN_BITS);
  localparam logic [SERIAL_ACC_LEN_BITS-1:0] SAMP_MAX = '1;
  localparam logic [ANT_BITS-1:0] ANT_MAX = ANT_BITS'(N_ANTS - 1);

  seq_state_t                     r_state;
  seq_state_t                     w_next_state;
  logic [SERIAL_ACC_LEN_BITS-1:0] r_samp_ctr;
  logic [ANT_BITS-1:0]            r_ant_ctr;
  logic [WIN_CNT_BITS-1:0]        r_in_win;
  logic [INPUT_WIDTH-1:0]         r_tap_a;
  logic                           r_tap_rst;
  logic                           r_err_gap;
  logic                           w_at_start;
  logic                           w_first;
  logic                           w_take;
  logic                           w_gap;
  logic                           w_win_end;
  logic                           w_err_clr;

  // The sync cycle in WAIT_SYNC is itself sample 0; with arm low, RUN stops
  // taking samples once it reaches the window boundary.
  always_comb begin
    w_at_start = (r_samp_ctr == '0) && (r_ant_ctr == '0);
    w_first    = (r_state == ST_WAIT_SYNC) && arm && sync_in && din_valid;
    w_take     = w_first || ((r_state == ST_RUN) && din_valid && !(w_at_start && !arm));
    w_gap      = (r_state == ST_RUN) && !din_valid && !w_at_start;
    w_win_end  = w_take && (r_samp_ctr == SAMP_MAX) && (r_ant_ctr == ANT_MAX);
    w_err_clr  = ce && (r_state == ST_IDLE) && arm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else if (ce) r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (arm) w_next_state = ST_WAIT_SYNC;
      ST_WAIT_SYNC: begin
        if (!arm) w_next_state = ST_IDLE;
        else if (sync_in && din_valid) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (w_gap) w_next_state = ST_ABORT;
        else if (!arm && w_at_start) w_next_state = ST_IDLE;
      end
      ST_ABORT:     w_next_state = arm ? ST_WAIT_SYNC : ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    running = (r_state == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp_ctr <= '0;
      r_ant_ctr  <= '0;
      r_in_win   <= '0;
      r_tap_a    <= '0;
      r_tap_rst  <= 1'b0;
      r_err_gap  <= 1'b0;
    end else if (ce) begin
      if (w_take) begin
        r_samp_ctr <= r_samp_ctr + 1'b1;
        if (r_samp_ctr == SAMP_MAX) r_ant_ctr <= r_ant_ctr + 1'b1;
      end else if (r_state != ST_RUN) begin
        r_samp_ctr <= '0;
        r_ant_ctr  <= '0;
      end
      if (w_win_end) r_in_win <= r_in_win + 1'b1;
      r_tap_a   <= w_take ? din : '0;
      r_tap_rst <= w_take && w_at_start;
      if (w_err_clr) r_err_gap <= 1'b0;
      else if (w_gap) r_err_gap <= 1'b1;
    end
  end

  assign tap_a   = r_tap_a;
  assign tap_rst = r_tap_rst;
  assign err_gap = r_err_gap;

  xeng_res_tagger #(
    .ACC_WIDTH    (ACC_WIDTH),
    .RES_PER_WIN  (RES_PER_WIN),
    .BL_BITS      (BL_BITS),
    .WIN_CNT_BITS (WIN_CNT_BITS),
    .MARK_DELAY   (MARK_DELAY)
  ) u_tagger (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ce        (ce),
    .i_tap_rst   (r_tap_rst),
    .i_err_clr   (w_err_clr),
    .i_acc_valid (acc_valid_in),
    .i_acc       (acc_in),
    .o_acc       (acc_out),
    .o_acc_valid (acc_valid_out),
    .o_bl_idx    (bl_idx),
    .o_win_idx   (win_idx),
    .o_err_cnt   (err_cnt)
  );

endmodule

// File: tb/tb_xeng_seq_ctrl.sv
// Directed bench for xeng_seq_ctrl with 4 antennas and 4 samples per antenna
// per window (16-sample windows, 12 results per window, 12-cycle marker delay).
module tb_xeng_seq_ctrl;

  localparam int SALB = 2;
  localparam int PFB  = 0;
  localparam int BW   = 4;
  localparam int NA   = 4;
  localparam int WCB  = 16;
  localparam int IW   = 16;
  localparam int AW   = 88;
  localparam int BLW  = 4;
  localparam int RES  = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ce;
  logic           arm;
  logic           sync_in;
  logic           din_valid;
  logic [IW-1:0]  din;
  logic [IW-1:0]  tap_a;
  logic           tap_rst;
  logic [AW-1:0]  acc_in;
  logic           acc_valid_in;
  logic [AW-1:0]  acc_out;
  logic           acc_valid_out;
  logic [BLW-1:0] bl_idx;
  logic [WCB-1:0] win_idx;
  logic           running;
  logic           err_gap;
  logic           err_cnt;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic          arm;
    logic          sync;
    logic          valid;
    logic [IW-1:0] din;
    logic          expRun;
    logic [IW-1:0] expTapA;
    logic          expTapRst;
    logic          expErrGap;
    logic [WCB-1:0] expInWin;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  xeng_seq_ctrl #(
    .SERIAL_ACC_LEN_BITS (SALB),
    .P_FACTOR_BITS       (PFB),
    .BITWIDTH            (BW),
    .N_ANTS              (NA),
    .WIN_CNT_BITS        (WCB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ce            (ce),
    .arm           (arm),
    .sync_in       (sync_in),
    .din_valid     (din_valid),
    .din           (din),
    .tap_a         (tap_a),
    .tap_rst       (tap_rst),
    .acc_in        (acc_in),
    .acc_valid_in  (acc_valid_in),
    .acc_out       (acc_out),
    .acc_valid_out (acc_valid_out),
    .bl_idx        (bl_idx),
    .win_idx       (win_idx),
    .running       (running),
    .err_gap       (err_gap),
    .err_cnt       (err_cnt)
  );

  function automatic vec_t mkVec(input logic a, input logic s, input logic v, input logic [IW-1:0] d,
                                 input logic eRun, input logic [IW-1:0] eTapA, input logic eRst,
                                 input logic eGap, input logic [WCB-1:0] eWin);
    vec_t t;
    t.arm = a; t.sync = s; t.valid = v; t.din = d;
    t.expRun = eRun; t.expTapA = eTapA; t.expTapRst = eRst; t.expErrGap = eGap; t.expInWin = eWin;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cEn, input logic a, input logic s, input logic v,
                               input logic [IW-1:0] d, input logic av, input logic [AW-1:0] ai);
    @(negedge clk);
    ce = cEn; arm = a; sync_in = s; din_valid = v; din = d;
    acc_valid_in = av; acc_in = ai;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // One-sample window start followed by a gap: emits a tap_rst, then waits out the marker delay.
  task automatic triggerMarker();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h7000, 1'b0, '0);
    checkOutput("trig_tap_rst", 128'(tap_rst), 128'(1'b1));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    idleCycles(14);
  endtask

  task automatic sendResult(input string tag, input int k, input int expBl, input int expWin,
                            input logic chkWin, input logic expErr);
    logic [AW-1:0] val;
    val = AW'(64'hC0DE_0000_0000) + AW'(k);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, val);
    checkOutput({tag, "_valid"}, 128'(acc_valid_out), 128'(1'b1));
    checkOutput({tag, "_acc"}, 128'(acc_out), 128'(val));
    checkOutput({tag, "_bl"}, 128'(bl_idx), 128'(expBl));
    if (chkWin) checkOutput({tag, "_win"}, 128'(win_idx), 128'(expWin));
    checkOutput({tag, "_errcnt"}, 128'(err_cnt), 128'(expErr));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1; ce = 1'b1; arm = 1'b0; sync_in = 1'b0; din_valid = 1'b0;
    din = '0; acc_valid_in = 1'b0; acc_in = '0;

    vecs.push_back(mkVec(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mkVec(1, (i == 0 || i == 5), 1, 16'h1000 + 16'(i * 17), 1, 16'h1000 + 16'(i * 17),
                           (i == 0), 0, (i == 15) ? 16'd1 : 16'd0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkVec(1, 0, 1, 16'h2000 + 16'(i), 1, 16'h2000 + 16'(i), (i == 0), 0, 1));
    vecs.push_back(mkVec(1, 0, 0, 16'hDEAD, 0, 16'h0000, 0, 1, 1));
    vecs.push_back(mkVec(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 1));
    vecs.push_back(mkVec(1, 1, 1, 16'h3000, 1, 16'h3000, 1, 1, 1));
    vecs.push_back(mkVec(1, 1, 1, 16'h3001, 1, 16'h3001, 0, 1, 1));
    vecs.push_back(mkVec(1, 0, 1, 16'h3002, 1, 16'h3002, 0, 1, 1));

    #1 rst_n = 1'b0;
    #16;
    checkOutput("reset_outputs", {tap_a, tap_rst, running, err_gap, err_cnt, acc_valid_out, bl_idx, win_idx},
                128'd0);
    checkOutput("reset_in_win", 128'(dut.r_in_win), 128'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b1, vecs[i].arm, vecs[i].sync, vecs[i].valid, vecs[i].din, 1'b0, '0);
      checkOutput($sformatf("vec%0d_running", i), 128'(running), 128'(vecs[i].expRun));
      checkOutput($sformatf("vec%0d_tap_a", i), 128'(tap_a), 128'(vecs[i].expTapA));
      checkOutput($sformatf("vec%0d_tap_rst", i), 128'(tap_rst), 128'(vecs[i].expTapRst));
      checkOutput($sformatf("vec%0d_err_gap", i), 128'(err_gap), 128'(vecs[i].expErrGap));
      checkOutput($sformatf("vec%0d_in_win", i), 128'(dut.r_in_win), 128'(vecs[i].expInWin));
    end

    // Asynchronous reset mid-window, away from any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_outputs", {tap_a, tap_rst, running, err_gap, err_cnt, acc_valid_out, bl_idx, win_idx},
                128'd0);
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h5000, 1'b0, '0);
    checkOutput("post_rst_no_arm_running", 128'(running), 128'(1'b0));
    checkOutput("post_rst_no_arm_tap_a", 128'(tap_a), 128'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h5001, 1'b0, '0);
    checkOutput("post_rst_arm_running", 128'(running), 128'(1'b0));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h5002, 1'b0, '0);
    checkOutput("post_rst_sync_running", 128'(running), 128'(1'b1));
    checkOutput("post_rst_sync_tap_rst", 128'(tap_rst), 128'(1'b1));
    checkOutput("post_rst_sync_tap_a", 128'(tap_a), 128'(16'h5002));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("post_rst_gap_err", 128'(err_gap), 128'(1'b1));
    idleCycles(16);

    // Full windows of results, then a short window caught by the marker.
    for (int k = 0; k < RES; k++) sendResult($sformatf("resA%0d", k), k, k, 0, 1'b1, 1'b0);
    triggerMarker();
    for (int k = 0; k < RES; k++) sendResult($sformatf("resB%0d", k), 100 + k, k, 1, 1'b1, 1'b0);
    for (int k = 0; k < RES - 1; k++) sendResult($sformatf("resC%0d", k), 200 + k, k, 2, 1'b1, 1'b0);
    triggerMarker();
    sendResult("resShort", 300, 0, 0, 1'b0, 1'b1);

    // Flags survive a drop to IDLE and clear on re-arm.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("idle_err_gap_held", 128'(err_gap), 128'(1'b1));
    checkOutput("idle_err_cnt_held", 128'(err_cnt), 128'(1'b1));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("rearm_err_gap_clr", 128'(err_gap), 128'd0);
    checkOutput("rearm_err_cnt_clr", 128'(err_cnt), 128'd0);

    // Clock-enable stall mid-window; valid pulses during the stall are dropped.
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        for (int j = 0; j < 3; j++) begin
          applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'hBAD0, 1'b1, AW'(64'hBAD));
          checkOutput($sformatf("ce_hold%0d_tap_a", j), 128'(tap_a), 128'(16'h4005));
          checkOutput($sformatf("ce_hold%0d_tap_rst", j), 128'(tap_rst), 128'd0);
          checkOutput($sformatf("ce_hold%0d_running", j), 128'(running), 128'(1'b1));
          checkOutput($sformatf("ce_hold%0d_acc_valid", j), 128'(acc_valid_out), 128'd0);
          checkOutput($sformatf("ce_hold%0d_in_win", j), 128'(dut.r_in_win), 128'd0);
        end
      end
      applyStimulus(1'b1, 1'b1, (i == 0), 1'b1, 16'h4000 + 16'(i), 1'b0, '0);
      checkOutput($sformatf("ce_w1s%0d_tap_a", i), 128'(tap_a), 128'(16'h4000 + 16'(i)));
      checkOutput($sformatf("ce_w1s%0d_tap_rst", i), 128'(tap_rst), 128'(i == 0));
      checkOutput($sformatf("ce_w1s%0d_in_win", i), 128'(dut.r_in_win), 128'((i == 15) ? 1 : 0));
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, (i == 0), 1'b0, 1'b1, 16'h4100 + 16'(i), 1'b0, '0);
      checkOutput($sformatf("disarm_s%0d_running", i), 128'(running), 128'(1'b1));
      checkOutput($sformatf("disarm_s%0d_tap_rst", i), 128'(tap_rst), 128'(i == 0));
      checkOutput($sformatf("disarm_s%0d_in_win", i), 128'(dut.r_in_win), 128'((i == 15) ? 2 : 1));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h4FFF, 1'b0, '0);
    checkOutput("disarm_idle_running", 128'(running), 128'd0);
    checkOutput("disarm_idle_tap_a", 128'(tap_a), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
